// File: rtl/latch_dump_reader.sv
// Reader side of the debug latch-select mux. It walks every valid select code,
// captures each returned word and streams it to the UART as bytes after a sync header.
module latch_dump_reader #(
  parameter int         DATA_WIDTH = 32,
  parameter int         CTRL_WIDTH = 7,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter bit         LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic [CTRL_WIDTH-1:0] out_control,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE  = BCW'(NUM_BYTES - 1);
  localparam logic [4:0]     LAST_INDEX = 5'd18;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEL  = 3'd2,
    WAIT = 3'd3,
    CAPT = 3'd4,
    SEND = 3'd5,
    TXW  = 3'd6
  } stateType;

  stateType              state_r;
  logic [4:0]            index_r;
  logic [BCW-1:0]        byteCnt_r;
  logic [DATA_WIDTH-1:0] shiftReg_r;
  logic                  hdrFlag_r;

  // Ordered list of valid select codes; code 22 has no latch behind it.
  function automatic logic [CTRL_WIDTH-1:0] codeRom(input logic [4:0] idx);
    case (idx)
      5'd0:    codeRom = CTRL_WIDTH'(7'h00);
      5'd1:    codeRom = CTRL_WIDTH'(7'h01);
      5'd2:    codeRom = CTRL_WIDTH'(7'h10);
      5'd3:    codeRom = CTRL_WIDTH'(7'h11);
      5'd4:    codeRom = CTRL_WIDTH'(7'h12);
      5'd5:    codeRom = CTRL_WIDTH'(7'h13);
      5'd6:    codeRom = CTRL_WIDTH'(7'h14);
      5'd7:    codeRom = CTRL_WIDTH'(7'h15);
      5'd8:    codeRom = CTRL_WIDTH'(7'h20);
      5'd9:    codeRom = CTRL_WIDTH'(7'h21);
      5'd10:   codeRom = CTRL_WIDTH'(7'h23);
      5'd11:   codeRom = CTRL_WIDTH'(7'h24);
      5'd12:   codeRom = CTRL_WIDTH'(7'h25);
      5'd13:   codeRom = CTRL_WIDTH'(7'h30);
      5'd14:   codeRom = CTRL_WIDTH'(7'h31);
      5'd15:   codeRom = CTRL_WIDTH'(7'h32);
      5'd16:   codeRom = CTRL_WIDTH'(7'h33);
      5'd17:   codeRom = CTRL_WIDTH'(7'h40);
      5'd18:   codeRom = CTRL_WIDTH'(7'h41);
      default: codeRom = CTRL_WIDTH'(7'h00);
    endcase
  endfunction

  // Dump sequencer: header, then select/settle/capture/serialise per code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      index_r     <= 5'd0;
      byteCnt_r   <= {BCW{1'b0}};
      shiftReg_r  <= {DATA_WIDTH{1'b0}};
      hdrFlag_r   <= 1'b0;
      out_control <= {CTRL_WIDTH{1'b0}};
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            state_r <= HDR;
          end
        end
        HDR: begin
          if (!tx_busy) begin
            tx_data   <= SYNC_BYTE;
            tx_start  <= 1'b1;
            hdrFlag_r <= 1'b1;
            state_r   <= TXW;
          end
        end
        SEL: begin
          out_control <= codeRom(index_r);
          state_r     <= WAIT;
        end
        // The mux registers its output one edge after the select changes.
        WAIT: begin
          state_r <= CAPT;
        end
        CAPT: begin
          shiftReg_r <= in_data;
          byteCnt_r  <= {BCW{1'b0}};
          state_r    <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            if (LSB_FIRST) begin
              tx_data    <= shiftReg_r[7:0];
              shiftReg_r <= shiftReg_r >> 4'd8;
            end else begin
              tx_data    <= shiftReg_r[DATA_WIDTH-1 -: 8];
              shiftReg_r <= shiftReg_r << 4'd8;
            end
            tx_start <= 1'b1;
            state_r  <= TXW;
          end
        end
        TXW: begin
          if (tx_done) begin
            if (hdrFlag_r) begin
              hdrFlag_r <= 1'b0;
              index_r   <= 5'd0;
              state_r   <= SEL;
            end else if (byteCnt_r < LAST_BYTE) begin
              byteCnt_r <= byteCnt_r + 1'b1;
              state_r   <= SEND;
            end else if (index_r < LAST_INDEX) begin
              index_r <= index_r + 5'd1;
              state_r <= SEL;
            end else begin
              done        <= 1'b1;
              busy        <= 1'b0;
              out_control <= {CTRL_WIDTH{1'b0}};
              state_r     <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_dump_reader.sv
// Directed bench for latch_dump_reader: two instances (LSB-first and MSB-first)
// share one mux model and one UART model and run in lockstep.
module tb_latch_dump_reader;

  localparam logic [6:0] ROMTAB [19] = '{7'h00, 7'h01, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14,
                                         7'h15, 7'h20, 7'h21, 7'h23, 7'h24, 7'h25, 7'h30,
                                         7'h31, 7'h32, 7'h33, 7'h40, 7'h41};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, tx_busy, tx_done;
  logic [31:0] in_data;
  logic [6:0]  ctrl1, ctrl2;
  logic [7:0]  txData1, txData2;
  logic        txStart1, txStart2, busy1, busy2, done1, done2;

  latch_dump_reader #(.DATA_WIDTH(32), .CTRL_WIDTH(7), .SYNC_BYTE(8'hA5), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .out_control(ctrl1), .tx_data(txData1), .tx_start(txStart1), .busy(busy1), .done(done1));

  latch_dump_reader #(.DATA_WIDTH(32), .CTRL_WIDTH(7), .SYNC_BYTE(8'hA5), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .out_control(ctrl2), .tx_data(txData2), .tx_start(txStart2), .busy(busy2), .done(done2));

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  bit bpMode = 1'b0;

  // Mux model: one registered cycle of latency; mode 1 emits DEADBEEF for one cycle after a select change.
  logic [31:0] muxReg;
  logic [6:0]  prevCtrl;
  always @(posedge clk) begin
    prevCtrl <= ctrl1;
    if (mode == 1) muxReg <= (ctrl1 != prevCtrl) ? 32'hDEADBEEF : 32'h0000_0000;
    else           muxReg <= {1'b0, ctrl1, 24'h00BEEF};
  end
  assign in_data = muxReg;

  // Monitor plus UART model: tx_done 10 cycles after each tx_start, optional 50-cycle busy hold.
  logic [7:0] q1[$], q2[$];
  logic [6:0] cq[$];
  int   pend = 0, busyCnt = 0, doneCnt = 0, bpViol = 0, doneBad = 0, seen22 = 0;
  logic prevBusy = 1'b0;
  always @(negedge clk) begin
    if (txStart1) begin
      q1.push_back(txData1);
      q2.push_back(txData2);
      cq.push_back(ctrl1);
      if (tx_busy) bpViol++;
    end
    if (done1) begin
      doneCnt++;
      if (busy1 || !prevBusy) doneBad++;
    end
    if (ctrl1 == 7'h22) seen22++;
    tx_done = 1'b0;
    if (rst) begin
      pend    = 0;
      busyCnt = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          tx_done = 1'b1;
          if (bpMode) busyCnt = 50;
        end
      end else if (busyCnt > 0) begin
        busyCnt--;
      end
      if (txStart1) pend = 10;
      if (bpMode && busy1 && !prevBusy) busyCnt = 50;
    end
    tx_busy  = bpMode && (pend > 0 || busyCnt > 0);
    prevBusy = busy1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expByte(input int w, input int b, input bit lsb, input int m);
    logic [31:0] word;
    int pos;
    word = (m == 1) ? 32'hDEADBEEF : {1'b0, ROMTAB[w], 24'h00BEEF};
    pos  = lsb ? b : 3 - b;
    return word[pos*8 +: 8];
  endfunction

  task automatic startDump();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc, output bit to);
    to = 1'b1;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (!busy1) begin
        to = 1'b0;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic waitBytes(input int base, input int n, input int maxCyc, output bit to);
    to = 1'b1;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (q1.size() - base >= n) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic checkWords(input int base, input int firstW, input int m, input string tag);
    int b1 = 0, b2 = 0, bc = 0, idx;
    if (q1.size() < base + 77) begin
      b1 = 77; b2 = 77; bc = 77;
    end else begin
      if (q1[base] !== 8'hA5) b1++;
      if (q2[base] !== 8'hA5) b2++;
      for (int w = firstW; w < 19; w++) begin
        for (int b = 0; b < 4; b++) begin
          idx = base + 1 + w*4 + b;
          if (q1[idx] !== expByte(w, b, 1'b1, m)) b1++;
          if (q2[idx] !== expByte(w, b, 1'b0, m)) b2++;
          if (cq[idx] !== ROMTAB[w]) bc++;
        end
      end
    end
    chk({tag, " lsb bytes"}, b1, 0);
    chk({tag, " msb bytes"}, b2, 0);
    chk({tag, " ctrl seq"}, bc, 0);
  endtask

  initial begin
    int base, d0;
    bit to;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst out_control", ctrl1, 0);
    chk("rst tx_data", txData1, 0);
    chk("rst tx_start", txStart1, 0);
    chk("rst busy", busy1, 0);
    chk("rst done", done1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic dump with latency and byte ordering
    base = q1.size(); d0 = doneCnt;
    startDump();
    chk("busy after start", busy1, 1);
    chk("no early tx_start", txStart1, 0);
    @(negedge clk);
    chk("hdr tx_start", txStart1, 1);
    chk("hdr byte", txData1, 8'hA5);
    waitIdle(3000, to);
    chk("basic timeout", to, 0);
    chk("basic count", q1.size() - base, 77);
    chk("basic done count", doneCnt - d0, 1);
    chk("done with busy low", doneBad, 0);
    chk("ctrl idle", ctrl1, 0);
    chk("code13 lsb", {q1[base+21], q1[base+22], q1[base+23], q1[base+24]}, 32'hEFBE0013);
    chk("code13 msb", {q2[base+21], q2[base+22], q2[base+23], q2[base+24]}, 32'h1300BEEF);
    checkWords(base, 0, 0, "basic");

    // Capture timing: word visible for one cycle only
    mode = 1;
    base = q1.size();
    startDump();
    waitIdle(3000, to);
    chk("capt timeout", to, 0);
    chk("capt count", q1.size() - base, 77);
    checkWords(base, 1, 1, "capt");
    mode = 0;

    // Back-pressure
    bpMode = 1'b1;
    base = q1.size();
    startDump();
    waitIdle(12000, to);
    chk("bp timeout", to, 0);
    chk("bp count", q1.size() - base, 77);
    chk("tx_start while busy", bpViol, 0);
    checkWords(base, 0, 0, "bp");
    bpMode = 1'b0;
    repeat (2) @(negedge clk);

    // Start while busy is ignored
    base = q1.size(); d0 = doneCnt;
    startDump();
    waitBytes(base, 20, 2000, to);
    chk("byte20 timeout", to, 0);
    startDump();
    waitIdle(3000, to);
    chk("sb timeout", to, 0);
    chk("sb count", q1.size() - base, 77);
    chk("sb done count", doneCnt - d0, 1);
    repeat (5) @(negedge clk);
    chk("sb no requeue", busy1, 0);
    base = q1.size();
    startDump();
    @(negedge clk);
    chk("restart hdr", {txStart1, txData1}, {1'b1, 8'hA5});
    waitIdle(3000, to);
    chk("restart count", q1.size() - base, 77);

    // Reset mid-dump
    base = q1.size(); d0 = doneCnt;
    startDump();
    waitBytes(base, 40, 2000, to);
    chk("byte40 timeout", to, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", busy1, 0);
    chk("abort ctrl", ctrl1, 0);
    chk("abort tx_start", txStart1, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort no done", doneCnt - d0, 0);
    chk("abort idle", busy1, 0);
    base = q1.size();
    startDump();
    @(negedge clk);
    chk("post-abort hdr", {txStart1, txData1}, {1'b1, 8'hA5});
    waitIdle(3000, to);
    chk("post-abort timeout", to, 0);
    chk("post-abort count", q1.size() - base, 77);
    checkWords(base, 0, 0, "post-abort");
    chk("code 22 never seen", seen22, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/latch_dump_reader.md
Name: latch_dump_reader

Overview:
- Reader side of the pipeline debug latch-select mux: drives the 7-bit latch select code and captures the registered 32-bit word the mux returns.
- On a dump request, walks a fixed ordered list of all valid select codes and serialises each captured word into bytes for the debug UART transmitter.
- Sits between the debug unit's command decoder (start) and the UART TX (byte handshake); the pipeline is halted externally while a dump runs.

Parameters:
- DATA_WIDTH, 32, width of the word returned by the mux; must be a multiple of 8.
- CTRL_WIDTH, 7, width of the latch select code.
- SYNC_BYTE, 8'hA5, header byte sent before the first word of every dump.
- LSB_FIRST, 1, byte order per word: 1 sends bits 7:0 first, 0 sends bits 31:24 first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  dump request pulse; sampled only in IDLE.
- in_data  input  DATA_WIDTH  registered word from the latch mux for the current select code.
- tx_busy  input  1  UART TX busy; a byte may be issued only when low.
- tx_done  input  1  one-cycle pulse from UART TX when the byte issued has finished.
- out_control  output  CTRL_WIDTH  latch select code driven to the mux.
- tx_data  output  8  byte to transmit; stable from tx_start until tx_done.
- tx_start  output  1  one-cycle byte-issue strobe.
- busy  output  1  high from the cycle after start is accepted until the last tx_done.
- done  output  1  one-cycle pulse in the cycle after the last byte's tx_done.

Behaviour:
- Reset (clk, rst) is synchronous and active-high; single clock domain. On reset: state=IDLE, out_control=0, tx_data=0, tx_start=0, busy=0, done=0, index=0, byte counter=0.
- Code list, fixed ROM, in order, 19 entries: 00,01,10,11,12,13,14,15,20,21,23,24,25,30,31,32,33,40,41 (hex). Code 22 is never issued.
- FSM states: IDLE, HDR, SEL, WAIT, CAPT, SEND, TXW.
- IDLE: on start=1, go to HDR and set busy=1.
- HDR: when tx_busy=0, load tx_data=SYNC_BYTE, pulse tx_start, go to TXW with hdr flag set.
- SEL: drive out_control=ROM[index]; go to WAIT.
- WAIT: hold for one cycle. The mux registers in_data on the edge after out_control changes.
- CAPT: capture in_data into the shift register and clear the byte counter. The capture edge is 2 clocks after out_control changes. Go to SEND.
- SEND: when tx_busy=0, present the selected byte, pulse tx_start for exactly one cycle, and go to TXW.
- TXW: wait for tx_done.
  - If the hdr flag is set: clear it, set index=0, go to SEL.
  - Else if byte counter < DATA_WIDTH/8-1: increment it and go to SEND.
  - Else if index < 18: increment index and go to SEL.
  - Else: pulse done, clear busy, set out_control=0, go to IDLE.
- Total bytes per dump: 1 + 19*4 = 77 at default width.
- start while busy=1 is ignored, with no queuing.
- tx_done outside TXW is ignored. tx_start is never asserted while tx_busy=1.
- tx_done in the same cycle as the transition into TXW cannot occur. tx_done is accepted on the first cycle of TXW.
- out_control holds its value through CAPT, SEND and TXW; it changes only in SEL and at completion.
- in_data is sampled only in CAPT. Changes at other times do not affect bytes already captured.
- Reset during any state aborts the dump immediately: no done pulse, tx_start=0 in the following cycle, returns to IDLE.
- The byte counter and index never wrap. The terminal conditions above are exact.
- Latency from start to first tx_start is 2 cycles with tx_busy=0: 1 cycle to IDLE→HDR, 1 cycle to issue.

Test Plan:
- Reset then idle: rst=1 for 3 cycles → all outputs 0. Pulse start, tx_busy=0, UART model returns tx_done 10 cycles after each tx_start → first byte A5, total 77 tx_start pulses, done pulses once, busy falls in the same cycle as done.
- Data ordering: mux model returns {code, 24'h00BEEF} delayed by 1 registered cycle → for code 13 the bytes are EF, BE, 00, 13 with LSB_FIRST=1, and 13, 00, BE, EF with LSB_FIRST=0. out_control sequence matches the ROM list; 22 is never seen.
- Capture timing: in_data changes to DEADBEEF exactly 1 cycle after out_control changes and to 0 one cycle later → captured word is DEADBEEF. Changes during SEND do not alter the bytes sent.
- TX back-pressure: tx_busy=1 held 50 cycles before each byte → no tx_start while tx_busy=1; byte content unchanged; still 77 bytes.
- Start while busy: pulse start at byte 20 → ignored, exactly 77 bytes, one done. A second start after done → a new dump begins with A5.
- Reset mid-dump: assert rst during byte 40 TXW → next cycle busy=0, out_control=0, no done. A subsequent start restarts from the header.
